// File: rtl/pos_pkg.sv
// Shared opcodes, FSM states and ASCII constants for the POS order accumulator.
package pos_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_REMOVE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_CONVERT,
    ST_DONE
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: loads on start, then one add-3/shift step per cycle for SUM_W cycles.
module bin2bcd_serial #(
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  lcd_clk_33m,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SUM_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    adj    = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CNT_W'(SUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the cycle whose closing edge performs the final shift
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/pos_order_accum.sv
// Order accumulator: price table, per-item saturating quantities, running total and
// a right-aligned ASCII rendering of the total refreshed after every accepted command.
module pos_order_accum
  import pos_pkg::*;
#(
  parameter int unsigned N_ITEMS = 8,
  parameter int unsigned PRICE_W = 16,
  parameter int unsigned QTY_W   = 4,
  parameter int unsigned SUM_W   = 24,
  parameter int unsigned DIGITS  = 8
) (
  input  logic                                 lcd_clk_33m,
  input  logic                                 rst_n,
  input  logic                                 price_we,
  input  logic [$clog2(N_ITEMS)-1:0]           price_idx,
  input  logic [PRICE_W-1:0]                   price_data,
  input  logic                                 cmd_valid,
  input  logic [1:0]                           cmd_op,
  input  logic [$clog2(N_ITEMS)-1:0]           cmd_idx,
  output logic                                 cmd_ready,
  output logic                                 cmd_err,
  output logic [SUM_W-1:0]                     total,
  output logic [QTY_W+$clog2(N_ITEMS)-1:0]     item_count,
  output logic [8*DIGITS-1:0]                  disp_str,
  output logic                                 disp_valid
);

  localparam int unsigned IDX_W    = $clog2(N_ITEMS);
  localparam int unsigned IDX_SPAN = 1 << IDX_W;
  localparam int unsigned CNT_W    = QTY_W + IDX_W;

  function automatic logic [IDX_SPAN-1:0] idx_mask();
    logic [IDX_SPAN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < IDX_SPAN; i++) m[i] = (i < N_ITEMS);
    return m;
  endfunction

  function automatic logic [8*DIGITS-1:0] blank_zero();
    logic [8*DIGITS-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < DIGITS; i++) s[8*i +: 8] = (i == 0) ? ASCII_ZERO : ASCII_SPACE;
    return s;
  endfunction

  // Index space is padded to a power of two; entries beyond N_ITEMS are never written.
  localparam logic [IDX_SPAN-1:0] IDX_OK    = idx_mask();
  localparam logic [8*DIGITS-1:0] RESET_STR = blank_zero();
  localparam logic [SUM_W:0]      SUM_MAX   = {1'b0, {SUM_W{1'b1}}};

  logic [PRICE_W-1:0]  price_q [IDX_SPAN];
  logic [PRICE_W-1:0]  price_d [IDX_SPAN];
  logic [QTY_W-1:0]    qty_q   [IDX_SPAN];
  logic [QTY_W-1:0]    qty_d   [IDX_SPAN];
  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PRICE_W-1:0]  sel_price_q, sel_price_d;
  logic [SUM_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic [8*DIGITS-1:0] disp_str_q, disp_str_d;
  logic                disp_valid_q, disp_valid_d;

  logic [SUM_W-1:0]    price_ext;
  logic [SUM_W:0]      add_sum;
  logic                conv_start, conv_busy, conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [8*DIGITS-1:0] fmt_str;
  logic                lead;

  assign price_ext = SUM_W'(sel_price_q);
  assign add_sum   = {1'b0, total_q} + {1'b0, price_ext};

  always_comb begin
    price_d      = price_q;
    qty_d        = qty_q;
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    sel_price_d  = sel_price_q;
    total_d      = total_q;
    count_d      = count_q;
    err_d        = 1'b0;
    disp_str_d   = disp_str_q;
    disp_valid_d = 1'b0;
    conv_start   = 1'b0;

    if (price_we && IDX_OK[price_idx]) price_d[price_idx] = price_data;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d        = op_e'(cmd_op);
          idx_d       = cmd_idx;
          sel_price_d = price_q[cmd_idx];
          state_d     = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        conv_start = 1'b1;
        state_d    = ST_CONVERT;
        unique case (op_q)
          OP_ADD: begin
            if (!IDX_OK[idx_q] || qty_q[idx_q] == '1 || add_sum > SUM_MAX) begin
              err_d = 1'b1;
            end else begin
              qty_d[idx_q] = qty_q[idx_q] + QTY_W'(1);
              total_d      = add_sum[SUM_W-1:0];
              count_d      = count_q + CNT_W'(1);
            end
          end
          OP_REMOVE: begin
            if (!IDX_OK[idx_q] || qty_q[idx_q] == '0) begin
              err_d = 1'b1;
            end else begin
              qty_d[idx_q] = qty_q[idx_q] - QTY_W'(1);
              total_d      = total_q - price_ext;
              count_d      = count_q - CNT_W'(1);
            end
          end
          OP_CLEAR: begin
            for (int unsigned i = 0; i < IDX_SPAN; i++) qty_d[i] = '0;
            total_d = '0;
            count_d = '0;
          end
          default: ;
        endcase
      end
      ST_CONVERT: begin
        if (conv_done || !conv_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_str_d   = fmt_str;
        disp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leading zeros blank to spaces; the units digit is always printed.
  always_comb begin
    fmt_str = '0;
    lead    = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (lead && conv_bcd[4*(DIGITS-1-j) +: 4] == 4'd0 && j != DIGITS - 1) begin
        fmt_str[8*(DIGITS-1-j) +: 8] = ASCII_SPACE;
      end else begin
        lead = 1'b0;
        fmt_str[8*(DIGITS-1-j) +: 8] = ASCII_ZERO | {4'h0, conv_bcd[4*(DIGITS-1-j) +: 4]};
      end
    end
  end

  bin2bcd_serial #(
    .SUM_W  (SUM_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .lcd_clk_33m (lcd_clk_33m),
    .rst_n       (rst_n),
    .start       (conv_start),
    .bin         (total_d),
    .busy        (conv_busy),
    .done        (conv_done),
    .bcd         (conv_bcd)
  );

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      price_q      <= '{default: '0};
      qty_q        <= '{default: '0};
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      idx_q        <= '0;
      sel_price_q  <= '0;
      total_q      <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      disp_str_q   <= RESET_STR;
      disp_valid_q <= 1'b0;
    end else begin
      price_q      <= price_d;
      qty_q        <= qty_d;
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      sel_price_q  <= sel_price_d;
      total_q      <= total_d;
      count_q      <= count_d;
      err_q        <= err_d;
      disp_str_q   <= disp_str_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign cmd_err    = err_q;
  assign total      = total_q;
  assign item_count = count_q;
  assign disp_str   = disp_str_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_pos_order_accum.sv
// Bench for pos_order_accum: directed table, hand sequences and random commands against a reference model.
module tb_pos_order_accum;
  import pos_pkg::*;

  localparam int N    = 8;
  localparam int SW   = 24;
  localparam int QMAX = 15;
  localparam longint SMAX = (longint'(1) << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        price_we, cmd_valid, cmd_ready, cmd_err, disp_valid;
  logic [2:0]  price_idx, cmd_idx;
  logic [15:0] price_data;
  logic [1:0]  cmd_op;
  logic [23:0] total;
  logic [6:0]  item_count;
  logic [63:0] disp_str;

  logic        s_we, s_valid, s_ready, s_err, s_dv;
  logic [2:0]  s_pidx, s_idx;
  logic [15:0] s_pdata;
  logic [1:0]  s_op;
  logic [15:0] s_total;
  logic [6:0]  s_count;
  logic [39:0] s_str;

  pos_order_accum dut (
    .lcd_clk_33m(clk), .rst_n(rst_n), .price_we(price_we), .price_idx(price_idx),
    .price_data(price_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .total(total), .item_count(item_count),
    .disp_str(disp_str), .disp_valid(disp_valid)
  );

  pos_order_accum #(.N_ITEMS(6), .PRICE_W(16), .QTY_W(4), .SUM_W(16), .DIGITS(5)) dut_s (
    .lcd_clk_33m(clk), .rst_n(rst_n), .price_we(s_we), .price_idx(s_pidx),
    .price_data(s_pdata), .cmd_valid(s_valid), .cmd_op(s_op), .cmd_idx(s_idx),
    .cmd_ready(s_ready), .cmd_err(s_err), .total(s_total), .item_count(s_count),
    .disp_str(s_str), .disp_valid(s_dv)
  );

  int checks = 0;
  int errors = 0;

  longint ref_price [N];
  longint ref_qty   [N];
  longint ref_total;

  typedef struct {
    logic [1:0] op;
    logic [2:0] idx;
    longint     total;
    longint     count;
    bit         err;
    string      s;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic logic [63:0] s2v(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*(s.len()-1-i) +: 8] = s[i];
    return r;
  endfunction

  function automatic longint ref_count();
    longint c = 0;
    for (int i = 0; i < N; i++) c += ref_qty[i];
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin ref_price[i] = 0; ref_qty[i] = 0; end
    ref_total = 0;
  endfunction

  // Applies one command to the model using the current price table; returns whether it is rejected.
  function automatic bit model_cmd(input int op, input int idx);
    bit rej = 0;
    case (op)
      0: if (idx >= N || ref_qty[idx] == QMAX || ref_total + ref_price[idx] > SMAX) rej = 1;
         else begin ref_qty[idx]++; ref_total += ref_price[idx]; end
      1: if (idx >= N || ref_qty[idx] == 0) rej = 1;
         else begin ref_qty[idx]--; ref_total = (ref_total - ref_price[idx]) & SMAX; end
      2: begin for (int i = 0; i < N; i++) ref_qty[i] = 0; ref_total = 0; end
      default: ;
    endcase
    return rej;
  endfunction

  task automatic write_price(input int idx, input int data);
    @(negedge clk);
    price_we = 1'b1; price_idx = 3'(idx); price_data = 16'(data);
    @(negedge clk);
    price_we = 1'b0;
    if (idx < N) ref_price[idx] = data;
  endtask

  task automatic do_cmd(input int op, input int idx, input bit pw, input int pw_idx, input int pw_data,
                        output longint o_total, output longint o_count, output bit o_err);
    bit rej;
    int n, w, lat, errs, err_at;
    longint tot1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_idx = 3'(idx);
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    chk("ready_before_accept", cmd_ready, 1);
    price_we = pw; price_idx = 3'(pw_idx); price_data = 16'(pw_data);
    rej = model_cmd(op, idx);
    if (pw && pw_idx < N) ref_price[pw_idx] = pw_data;
    @(negedge clk);
    cmd_valid = 1'b0; price_we = 1'b0;
    chk("ready_low_after_accept", cmd_ready, 0);
    n = 0; lat = -1; errs = 0; err_at = -1; tot1 = -1;
    while (n < 60) begin
      if (cmd_err) begin errs++; err_at = n; end
      if (n == 1) tot1 = total;
      if (disp_valid) begin lat = n; break; end
      @(negedge clk); n++;
    end
    chk("disp_latency", lat, SW + 2);
    chk("err_pulses", errs, rej ? 1 : 0);
    if (rej) chk("err_cycle", err_at, 1);
    chk("total_after_update", tot1, ref_total);
    chk("total", total, ref_total);
    chk("item_count", item_count, ref_count());
    chk_str("disp_str", disp_str, s2v($sformatf("%8d", ref_total)));
    chk("ready_in_valid_cycle", cmd_ready, 1);
    o_total = total; o_count = item_count; o_err = (errs != 0);
    @(negedge clk);
    chk("disp_valid_one_cycle", disp_valid, 0);
  endtask

  task automatic s_cmd(input int op, input int idx, input bit exp_err, input longint exp_total, input string exp_s);
    int n, w, lat, errs;
    @(negedge clk);
    s_valid = 1'b1; s_op = 2'(op); s_idx = 3'(idx);
    w = 0;
    while (!s_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    s_valid = 1'b0;
    n = 0; lat = -1; errs = 0;
    while (n < 60) begin
      if (s_err) errs++;
      if (s_dv) begin lat = n; break; end
      @(negedge clk); n++;
    end
    chk("s_latency", lat, 18);
    chk("s_err", errs, exp_err ? 1 : 0);
    chk("s_total", s_total, exp_total);
    chk_str("s_disp_str", {24'h0, s_str}, s2v(exp_s));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t   tbl [6];
    longint ot, oc;
    bit     oe;
    int     dvc, m, acc0, acc1, dv_at;

    tbl[0] = '{OP_ADD,    3'd0, 10000, 1, 1'b0, "   10000"};
    tbl[1] = '{OP_ADD,    3'd3, 14000, 2, 1'b0, "   14000"};
    tbl[2] = '{OP_ADD,    3'd3, 18000, 3, 1'b0, "   18000"};
    tbl[3] = '{OP_REMOVE, 3'd1, 18000, 3, 1'b1, "   18000"};
    tbl[4] = '{OP_NOP,    3'd0, 18000, 3, 1'b0, "   18000"};
    tbl[5] = '{OP_REMOVE, 3'd3, 14000, 2, 1'b0, "   14000"};

    rst_n = 1'b0;
    price_we = 0; price_idx = 0; price_data = 0; cmd_valid = 0; cmd_op = 0; cmd_idx = 0;
    s_we = 0; s_pidx = 0; s_pdata = 0; s_valid = 0; s_op = 0; s_idx = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    dvc = 0;
    repeat (5) begin @(negedge clk); if (disp_valid) dvc++; end
    chk("reset_ready", cmd_ready, 1);
    chk("reset_total", total, 0);
    chk("reset_count", item_count, 0);
    chk("reset_err", cmd_err, 0);
    chk("reset_no_disp_valid", dvc, 0);
    chk_str("reset_disp_str", disp_str, s2v("       0"));

    // Directed table
    write_price(0, 10000);
    write_price(3, 4000);
    for (int i = 0; i < 6; i++) begin
      do_cmd(tbl[i].op, tbl[i].idx, 0, 0, 0, ot, oc, oe);
      chk("tbl_total", ot, tbl[i].total);
      chk("tbl_count", oc, tbl[i].count);
      chk("tbl_err", oe, tbl[i].err);
      chk_str("tbl_str", disp_str, s2v(tbl[i].s));
    end

    // Quantity saturation
    do_cmd(OP_CLEAR, 0, 0, 0, 0, ot, oc, oe);
    write_price(0, 100);
    for (int i = 0; i < 16; i++) begin
      do_cmd(OP_ADD, 0, 0, 0, 0, ot, oc, oe);
      chk("sat_err", oe, (i == 15) ? 1 : 0);
    end
    chk("sat_total", ot, 1500);
    chk("sat_count", oc, 15);

    // Narrow instance: overflow, out-of-range index, 5-digit string
    @(negedge clk);
    s_we = 1'b1; s_pidx = 3'd0; s_pdata = 16'd40000;
    @(negedge clk);
    s_we = 1'b0;
    s_cmd(OP_ADD, 0, 0, 40000, "40000");
    s_cmd(OP_ADD, 0, 1, 40000, "40000");
    s_cmd(OP_ADD, 6, 1, 40000, "40000");
    s_cmd(OP_REMOVE, 0, 0, 0, "    0");
    s_cmd(OP_REMOVE, 0, 1, 0, "    0");

    // cmd_valid held while busy: second accept only in the disp_valid cycle
    write_price(1, 250);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_idx = 3'd1;
    acc0 = -1; acc1 = -1; dv_at = -1;
    for (m = 0; m < 80; m++) begin
      if (disp_valid && dv_at < 0) dv_at = m;
      if (cmd_valid && cmd_ready) begin
        if (acc0 < 0) acc0 = m;
        else begin acc1 = m; break; end
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    void'(model_cmd(OP_ADD, 1));
    void'(model_cmd(OP_ADD, 1));
    chk("hold_first_accept", acc0, 0);
    chk("hold_dv_latency", dv_at - (acc0 + 1), SW + 2);
    chk("hold_second_in_dv_cycle", acc1, dv_at);
    m = 0;
    while (!disp_valid && m < 60) begin @(negedge clk); m++; end
    chk("hold_second_done", disp_valid, 1);
    chk("hold_total", total, ref_total);
    chk("hold_count", item_count, ref_count());

    do_cmd(OP_CLEAR, 0, 0, 0, 0, ot, oc, oe);
    chk("clear_total", ot, 0);
    chk("clear_count", oc, 0);
    chk_str("clear_str", disp_str, s2v("       0"));

    // Same-edge price write: the command uses the old price
    write_price(2, 700);
    do_cmd(OP_ADD, 2, 1, 2, 900, ot, oc, oe);
    chk("old_price_total", ot, 700);
    do_cmd(OP_ADD, 2, 0, 0, 0, ot, oc, oe);
    chk("new_price_total", ot, 1600);

    // Random commands against the model
    for (int k = 0; k < 40; k++) begin
      int r, op, idx;
      r = $urandom_range(0, 9);
      op = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : 2;
      idx = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) == 0) write_price($urandom_range(0, N - 1), $urandom_range(0, 65535));
      do_cmd(op, idx, ($urandom_range(0, 4) == 0), $urandom_range(0, N - 1), $urandom_range(0, 65535), ot, oc, oe);
    end

    // Reset during CONVERT
    write_price(0, 500);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_idx = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_reset", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_total", total, 0);
    chk("rst_count", item_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_disp_valid", disp_valid, 0);
    chk_str("rst_str", disp_str, s2v("       0"));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dvc = 0;
    repeat (40) begin @(negedge clk); if (disp_valid) dvc++; end
    chk("no_dv_after_abort", dvc, 0);
    write_price(4, 1234);
    do_cmd(OP_ADD, 4, 0, 0, 0, ot, oc, oe);
    chk("post_reset_total", ot, 1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_order_accum.md
Name: pos_order_accum

Overview:
Sequential order accumulator for the POS display path: a runtime-loadable price table of N_ITEMS entries, a saturating quantity counter per item, and a running total. Every accepted command refreshes a right-aligned ASCII decimal string of the total through a serial binary-to-BCD converter. The string feeds the LCD text renderer in place of the combinational fixed-menu sum. Item commands come from the debounced, one-pulsed button/DIP logic.

Parameters:
N_ITEMS, 8, number of menu items (>=2)
PRICE_W, 16, price width in bits
QTY_W, 4, per-item quantity width; max quantity 2^QTY_W-1
SUM_W, 24, running-total width
DIGITS, 8, decimal characters in disp_str; must satisfy 10^DIGITS > 2^SUM_W-1

Ports:
lcd_clk_33m  in  1  clock
rst_n  in  1  asynchronous, active-low reset
price_we  in  1  price table write strobe
price_idx  in  $clog2(N_ITEMS)  price entry index
price_data  in  PRICE_W  price value
cmd_valid  in  1  command request
cmd_op  in  2  0=ADD, 1=REMOVE, 2=CLEAR, 3=NOP (refresh only)
cmd_idx  in  $clog2(N_ITEMS)  item index for ADD/REMOVE
cmd_ready  out  1  high only in IDLE
cmd_err  out  1  one-cycle pulse: the accepted command was rejected
total  out  SUM_W  running total
item_count  out  QTY_W+$clog2(N_ITEMS)  sum of all quantities
disp_str  out  8*DIGITS  ASCII total; MSB byte = leftmost character
disp_valid  out  1  one-cycle pulse when disp_str updates

Behaviour:
- Reset values: prices 0, quantities 0, total 0, item_count 0, cmd_ready 1, cmd_err 0, disp_valid 0, disp_str = (DIGITS-1) spaces followed by "0". Reset asserted mid-operation aborts the operation; no disp_valid follows.
- Price write: takes effect at the clock edge when price_we=1, in any state. Writes with price_idx >= N_ITEMS are ignored. A price change does not recompute total.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_op, cmd_idx and the addressed price are captured at the accept edge. If a price write hits the same index on that edge, the old price is used.
- FSM: IDLE -> UPDATE (accept edge) -> CONVERT (SUM_W shift cycles) -> DONE -> IDLE.
- UPDATE edge:
  - ADD: if qty==max, cmd_idx>=N_ITEMS, or total+price > 2^SUM_W-1, then cmd_err and no change. Otherwise qty+1 and total+price.
  - REMOVE: if qty==0 or cmd_idx>=N_ITEMS, then cmd_err and no change. Otherwise qty-1 and total-price.
  - CLEAR: all quantities 0, total 0; never errors.
  - NOP: no change.
  - cmd_err pulses in the cycle after UPDATE. total and item_count update on the UPDATE edge.
- CONVERT: double-dabble on the post-update total. Add 3 to each BCD nibble >=5, then shift; one bit per cycle, SUM_W cycles.
- DONE edge: load disp_str with ASCII digits. Leading zeros become spaces (0x20); the least significant digit is always shown. Pulse disp_valid.
- Latency: disp_valid is high in cycle accept+SUM_W+2. cmd_ready is low from the accept edge until the DONE edge and high again in the disp_valid cycle.
- cmd_valid while busy is ignored and must be held by the source; there is no queue.
- Erroneous commands still run CONVERT/DONE; disp_str is refreshed with an unchanged value.

Decomposition:
- pos_pkg: OP_ADD/OP_REMOVE/OP_CLEAR/OP_NOP, state encodings, ASCII_SPACE=8'h20, ASCII_ZERO=8'h30.
- Sub-module bin2bcd_serial (params SUM_W, DIGITS):
  - inputs: start, bin
  - outputs: busy, done, bcd[4*DIGITS]
  - the accumulator's CONVERT/DONE states wrap it.
- Leading-blank formatting stays in the top.

Test Plan:
1. Reset only -> cmd_ready=1, total=0, disp_str="       0", no disp_valid.
2. Prices idx0=10000, idx3=4000; ADD 0, ADD 3, ADD 3 -> total=18000, item_count=3, disp_str="   18000", each disp_valid exactly 26 cycles after accept.
3. REMOVE idx1 with qty 0 -> cmd_err pulse, total unchanged, disp_valid with same string; ADD idx=N_ITEMS -> cmd_err.
4. Price idx0=100, ADD 0 sixteen times (QTY_W=4) -> 15 accepted, 16th cmd_err, qty=15, total=1500. Separately, SUM_W=16, DIGITS=5, price 40000: ADD twice -> second cmd_err, total=40000, disp_str="40000".
5. cmd_valid held across CONVERT -> accepted only in the disp_valid cycle. Then CLEAR -> total=0, item_count=0, disp_str="       0". Price write to the same index on the ADD accept edge -> old price used.
6. rst_n low during CONVERT -> outputs reset immediately, no disp_valid. After release, ADD works normally.
